bus_mem_responder: RTL and testbench

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/bus_mem_responder_pkg.sv | 29 ++
 rtl/bus_mem_array.sv | 44 ++++
 rtl/bus_mem_responder.sv | 141 ++++++++++++++
 tb/tb_bus_mem_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_responder_pkg.sv
// Shared bus package for the memory responder.
// Holds the bus width constants, the one-hot FSM state encoding and a
// small address-window helper used by the responder's decode.
package bus_mem_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // One-hot encoding: exactly one bit set per state.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_STALL = 3'b010,
    S_RESP  = 3'b100
  } state_e;

  // True when addr lies in [base, base + span). The subtraction is done in
  // 33 bits so that windows touching the top of the address map do not wrap.
  function automatic logic addr_in_window(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W:0]   span
  );
    logic [ADDR_W:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (!off[ADDR_W]) && (off < span);
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Word-addressed storage for the bus responder.
// DEPTH x 32-bit words, per-byte write enables, one synchronous read port.
// The array carries no reset: contents survive a responder reset.
// Ports:
//   clk_i    clock
//   idx_i    word index shared by read and write
//   we_i     write strobe, be_i selects which bytes of wdata_i land
//   re_i     read strobe, rdata_o updates on the same edge
//   rdata_o  registered read data
module bus_mem_array
  import bus_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write and synchronous read of the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Single-outstanding bus memory responder.
// A request/grant handshake accepts one transfer, optionally after
// GNT_DELAY wait cycles, and answers it with a one-cycle rvalid_o strobe on
// the following cycle. Out-of-window addresses and byte-less writes are
// answered with err_o and leave storage untouched.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_i / gnt_o       handshake; accept = req_i && gnt_o
//   we_i, be_i, addr_i, wdata_i   transfer fields, sampled at accept
//   rvalid_o, rdata_o, err_o      response, valid one cycle after accept
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       GNT_DELAY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int unsigned     IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(DEPTH) * 33'd4;
  localparam logic [3:0]      DELAY = 4'(GNT_DELAY);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_s;
  logic              err_s;
  logic [IDX_W-1:0]  idx_s;
  logic              mem_we_s, mem_re_s;
  logic [DATA_W-1:0] mem_rdata_s;
  logic              rvalid_q, err_q, rd_ok_q;

  // Address decode. BASE_ADDR is DEPTH*4 aligned, so only the index bits of
  // the offset matter; the byte offset addr_i[1:0] is dropped.
  always_comb begin
    idx_s = addr_i[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
    err_s = (!addr_in_window(addr_i, BASE_ADDR, SPAN)) ||
            (we_i && (be_i == 4'b0000));
  end

  // Next-state, wait counter and combinational grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (DELAY == 4'd0) begin
            gnt_s   = 1'b1;
            cnt_d   = 4'd0;
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'd1;
            state_d = S_STALL;
          end
        end else begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end
      end
      S_STALL: begin
        if (!req_i) begin
          // Initiator withdrew: abandon the wait, nothing is accepted.
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else if (cnt_q == DELAY) begin
          gnt_s   = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = S_STALL;
        end
      end
      S_RESP: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Storage strobes: errored transfers never touch the array.
  always_comb begin
    mem_we_s = gnt_s && we_i && !err_s;
    mem_re_s = gnt_s && !we_i && !err_s;
  end

  // FSM state, wait counter and response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= gnt_s;
      err_q    <= gnt_s && err_s;
      rd_ok_q  <= mem_re_s;
    end
  end

  bus_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk),
    .idx_i   (idx_s),
    .we_i    (mem_we_s),
    .be_i    (be_i),
    .wdata_i (wdata_i),
    .re_i    (mem_re_s),
    .rdata_o (mem_rdata_s)
  );

  // Grant is masked while reset is held so the port reads 0 immediately.
  assign gnt_o    = gnt_s && rst_n;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  // Read data is exposed only in the response cycle of a good read.
  assign rdata_o  = rd_ok_q ? mem_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: one instance with no grant delay at
// base 0 and one with GNT_DELAY=3 at base 0x1000.
module tb_bus_mem_responder;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  be    = 4'b0000;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        sel   = 1'b0;

  logic        gnt_a, rvalid_a, err_a;
  logic [31:0] rdata_a;
  logic        gnt_b, rvalid_b, err_b;
  logic [31:0] rdata_b;

  logic        gnt_s, rvalid_s, err_s;
  logic [31:0] rdata_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0000_0000), .GNT_DELAY(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req_a), .gnt_o(gnt_a), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a)
  );

  bus_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0000_1000), .GNT_DELAY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req_b), .gnt_o(gnt_b), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b)
  );

  assign gnt_s    = sel ? gnt_b    : gnt_a;
  assign rvalid_s = sel ? rvalid_b : rvalid_a;
  assign err_s    = sel ? err_b    : err_a;
  assign rdata_s  = sel ? rdata_b  : rdata_a;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One transfer on the selected instance; returns wait cycles before grant
  // and the response seen in the cycle after accept.
  task automatic xfer(input logic s, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d,
                      output int waits, output logic rv,
                      output logic [31:0] rd, output logic e);
    waits = 0;
    @(negedge clk);
    sel = s; we = w; be = b; addr = a; wdata = d;
    if (s) req_b = 1'b1; else req_a = 1'b1;
    #1;
    while (!gnt_s && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    @(posedge clk);
    #1;
    req_a = 1'b0; req_b = 1'b0;
    we = ~w; be = ~b; addr = ~a; wdata = ~d;
    @(negedge clk);
    rv = rvalid_s; rd = rdata_s; e = err_s;
    @(negedge clk);
    check_eq("rvalid_one_cycle", {31'd0, rvalid_s}, 32'd0);
  endtask

  int          w_n;
  logic        rv;
  logic        e;
  logic [31:0] rd;

  task automatic expect_resp(input string tag, input int waits_exp, input logic e_exp,
                             input logic [31:0] rd_exp);
    check_eq({tag, "_waits"}, 32'(w_n), 32'(waits_exp));
    check_eq({tag, "_rvalid"}, {31'd0, rv}, 32'd1);
    check_eq({tag, "_err"}, {31'd0, e}, {31'd0, e_exp});
    check_eq({tag, "_rdata"}, rd, rd_exp);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_a_outs", {gnt_a, rvalid_a, err_a, 29'd0} | rdata_a, 32'd0);
    check_eq("rst_b_outs", {gnt_b, rvalid_b, err_b, 29'd0} | rdata_b, 32'd0);
    rst_n = 1'b1;

    // Zero-delay write/read and partial writes
    xfer(1'b0, 1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF, w_n, rv, rd, e);
    expect_resp("a_wr_full", 0, 1'b0, 32'h0);
    xfer(1'b0, 1'b0, 4'b0000, 32'h10, 32'h0, w_n, rv, rd, e);
    expect_resp("a_rd_full", 0, 1'b0, 32'hDEAD_BEEF);
    xfer(1'b0, 1'b1, 4'b0001, 32'h10, 32'h0000_00AA, w_n, rv, rd, e);
    xfer(1'b0, 1'b0, 4'b1111, 32'h10, 32'h0, w_n, rv, rd, e);
    expect_resp("a_rd_be0001", 0, 1'b0, 32'hDEAD_BEAA);
    xfer(1'b0, 1'b1, 4'b1100, 32'h12, 32'h1234_0000, w_n, rv, rd, e);
    xfer(1'b0, 1'b0, 4'b0000, 32'h13, 32'h0, w_n, rv, rd, e);
    expect_resp("a_rd_be1100", 0, 1'b0, 32'h1234_BEAA);

    // Delayed grant, window boundaries and error cases
    xfer(1'b1, 1'b1, 4'b1111, 32'h1000, 32'h5566_7788, w_n, rv, rd, e);
    expect_resp("b_wr_base", 3, 1'b0, 32'h0);
    xfer(1'b1, 1'b1, 4'b1111, 32'h13FC, 32'hA5A5_0F0F, w_n, rv, rd, e);
    expect_resp("b_wr_top", 3, 1'b0, 32'h0);
    xfer(1'b1, 1'b0, 4'b0000, 32'h1400, 32'h0, w_n, rv, rd, e);
    expect_resp("b_rd_above", 3, 1'b1, 32'h0);
    xfer(1'b1, 1'b0, 4'b1111, 32'h0FFC, 32'h0, w_n, rv, rd, e);
    expect_resp("b_rd_below", 3, 1'b1, 32'h0);
    xfer(1'b1, 1'b1, 4'b0000, 32'h1000, 32'hFFFF_FFFF, w_n, rv, rd, e);
    expect_resp("b_wr_nobe", 3, 1'b1, 32'h0);
    xfer(1'b1, 1'b0, 4'b0000, 32'h1000, 32'h0, w_n, rv, rd, e);
    expect_resp("b_rd_base", 3, 1'b0, 32'h5566_7788);
    xfer(1'b1, 1'b0, 4'b0000, 32'h13FF, 32'h0, w_n, rv, rd, e);
    expect_resp("b_rd_top", 3, 1'b0, 32'hA5A5_0F0F);

    // Request withdrawn during the stall: no grant, no response
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = 32'h1000; req_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("b_abort_gnt", {31'd0, gnt_b}, 32'd0);
      @(negedge clk);
    end
    req_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("b_abort_quiet", {30'd0, gnt_b, rvalid_b}, 32'd0);
      @(negedge clk);
    end
    xfer(1'b1, 1'b0, 4'b0000, 32'h1004, 32'h0, w_n, rv, rd, e);
    check_eq("b_after_abort_waits", 32'(w_n), 32'd3);

    // Reset during the response of a write
    @(negedge clk);
    sel = 1'b0; we = 1'b1; be = 4'b1111; addr = 32'h20; wdata = 32'hCAFE_F00D; req_a = 1'b1;
    #1;
    check_eq("a_rst_resp_gnt", {31'd0, gnt_a}, 32'd1);
    @(posedge clk);
    #1;
    req_a = 1'b0;
    check_eq("a_rst_resp_pre", {31'd0, rvalid_a}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("a_rst_resp_outs", {gnt_a, rvalid_a, err_a, 29'd0} | rdata_a, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("a_rst_resp_quiet", {31'd0, rvalid_a}, 32'd0);
    end
    xfer(1'b0, 1'b0, 4'b0000, 32'h20, 32'h0, w_n, rv, rd, e);
    expect_resp("a_persist", 0, 1'b0, 32'hCAFE_F00D);

    // Reset during a stall
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = 32'h1000; req_b = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("b_rst_stall_outs", {gnt_b, rvalid_b, err_b, 29'd0} | rdata_b, 32'd0);
    req_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("b_rst_stall_quiet", {31'd0, rvalid_b}, 32'd0);
    end
    xfer(1'b1, 1'b0, 4'b0000, 32'h1000, 32'h0, w_n, rv, rd, e);
    expect_resp("b_persist", 3, 1'b0, 32'h5566_7788);
    xfer(1'b0, 1'b0, 4'b0000, 32'h10, 32'h0, w_n, rv, rd, e);
    expect_resp("a_persist_10", 0, 1'b0, 32'h1234_BEAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
